// File: rtl/rs_encode.sv
// Systematic RS(255,239) encoder over GF(2^8), shortened-code capable.
// Message bytes pass straight through with one cycle of latency, followed by 16 parity bytes.
module rs_encode #(
  parameter int         NPAR      = 16,
  parameter logic [8:0] PRIM_POLY = 9'h11D,
  parameter int         KMAX      = 239
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       enable,
  input  logic [7:0] x,
  input  logic [7:0] k,
  output logic       in_ready,
  output logic [7:0] y,
  output logic       y_valid,
  output logic       y_par,
  output logic       done
);

  // Multiply two GF(2^8) elements by shift-and-add. When one operand is a
  // constant, this reduces to a fixed XOR network.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, s;
    r = '0;
    s = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ s;
      s = s[7] ? ({s[6:0], 1'b0} ^ PRIM_POLY[7:0]) : {s[6:0], 1'b0};
    end
    return r;
  endfunction

  // g(x) = prod (x + alpha^i) for i = 0..NPAR-1. The leading coefficient is
  // the implicit 1, so only g0..g(NPAR-1) are returned.
  function automatic logic [NPAR-1:0][7:0] gen_poly();
    logic [NPAR:0][7:0] c;
    logic [7:0]         a;
    c    = '0;
    c[0] = 8'h01;
    a    = 8'h01;
    for (int i = 0; i < NPAR; i++) begin
      for (int j = NPAR; j > 0; j--) c[j] = c[j-1] ^ gmul(c[j], a);
      c[0] = gmul(c[0], a);
      a    = gmul(a, 8'h02);
    end
    return c[NPAR-1:0];
  endfunction

  localparam logic [NPAR-1:0][7:0] G      = gen_poly();
  localparam logic [7:0]           KMAX_B = KMAX[7:0];
  localparam logic [7:0]           NPAR_B = NPAR[7:0];

  typedef enum logic [1:0] {IDLE, MSG, PAR} state_t;

  state_t                 state, state_n;
  logic [NPAR-1:0][7:0]   p, p_abs, p_sh;
  logic [7:0]             cnt, klat, klat_in, fb;
  logic                   accept;

  assign accept  = enable & in_ready;
  assign klat_in = (k == 8'd0 || k > KMAX_B) ? KMAX_B : k;
  assign fb      = x ^ p[NPAR-1];
  assign p_sh    = {p[NPAR-2:0], 8'h00};

  for (genvar i = 0; i < NPAR; i++) begin : g_tap
    if (i == 0) begin : g_low
      assign p_abs[i] = gmul(fb, G[i]);
    end else begin : g_hi
      assign p_abs[i] = p[i-1] ^ gmul(fb, G[i]);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = (klat_in == 8'd1) ? PAR : MSG;
      MSG:     if (accept && cnt == klat - 8'd1) state_n = PAR;
      PAR:     if (cnt == NPAR_B - 8'd1) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state != PAR);
  end

  // Datapath: cnt counts absorbed bytes in IDLE/MSG and shifted parity bytes in PAR.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      p       <= '0;
      cnt     <= '0;
      klat    <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      y_par   <= 1'b0;
      done    <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      y_par   <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE, MSG: begin
          if (accept) begin
            p       <= p_abs;
            y       <= x;
            y_valid <= 1'b1;
            if (state == IDLE) klat <= klat_in;
            cnt     <= (state_n == PAR) ? 8'd0 : cnt + 8'd1;
          end
        end
        PAR: begin
          y       <= p[NPAR-1];
          y_valid <= 1'b1;
          y_par   <= 1'b1;
          if (state_n == IDLE) begin
            done <= 1'b1;
            cnt  <= '0;
            p    <= '0;
          end else begin
            p    <= p_sh;
            cnt  <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_encode.sv
// Self-checking bench for rs_encode: directed and random blocks are checked against a
// log/antilog-table polynomial-division model, and every codeword is also checked for zero syndromes.
module tb_rs_encode;
  logic       clk = 1'b0, clrn = 1'b0, enable = 1'b0;
  logic [7:0] x = '0, k = '0;
  logic       in_ready, y_valid, y_par, done;
  logic [7:0] y;

  always #5 clk = ~clk;

  rs_encode dut (
    .clk(clk), .clrn(clrn), .enable(enable), .x(x), .k(k),
    .in_ready(in_ready), .y(y), .y_valid(y_valid), .y_par(y_par), .done(done)
  );

  int nchk = 0, nerr = 0;
  logic [7:0] gexp[0:255];
  int         glog[0:255];
  logic [7:0] gpoly[0:16];
  logic [7:0] msg[$];
  logic [7:0] obs_y[$], exp_y[$];
  bit         obs_par[$], obs_done[$], exp_par[$], exp_done[$];
  int         obs_cyc[$];
  int         cyc = 0, rdy_low = 0;

  // Output collector, sampled on the inactive edge.
  always @(negedge clk) begin
    cyc++;
    if (clrn) begin
      if (!in_ready) rdy_low++;
      if (y_valid) begin
        obs_y.push_back(y);
        obs_par.push_back(y_par);
        obs_done.push_back(done);
        obs_cyc.push_back(cyc);
      end
    end
  end

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected codeword: the message, then the remainder of m(x)*x^16 divided by g(x).
  task automatic build_exp(input int kk);
    logic [7:0] r[$];
    logic [7:0] c;
    r = {};
    for (int i = 0; i < kk; i++) begin
      r.push_back(msg[i]);
      exp_y.push_back(msg[i]);
      exp_par.push_back(1'b0);
      exp_done.push_back(1'b0);
    end
    repeat (16) r.push_back(8'h00);
    for (int j = 0; j < kk; j++) begin
      c = r[j];
      for (int m = 1; m <= 16; m++) r[j+m] = r[j+m] ^ gf_mul(c, gpoly[16-m]);
    end
    for (int m = 0; m < 16; m++) begin
      exp_y.push_back(r[kk+m]);
      exp_par.push_back(1'b1);
      exp_done.push_back(m == 15);
    end
  endtask

  function automatic int synd_or();
    int         s_or;
    logic [7:0] s;
    s_or = 0;
    for (int i = 0; i < 16; i++) begin
      s = 8'h00;
      foreach (obs_y[j]) s = gf_mul(s, gexp[i]) ^ obs_y[j];
      s_or = s_or | int'(s);
    end
    return s_or;
  endfunction

  task automatic clear_q();
    obs_y.delete(); obs_par.delete(); obs_done.delete(); obs_cyc.delete();
    exp_y.delete(); exp_par.delete(); exp_done.delete();
  endtask

  task automatic check_block(input string tag, input bit synd);
    int bad, idx, n;
    bad = -1;
    n   = exp_y.size();
    chk({tag, "_len"}, obs_y.size(), n);
    if (obs_y.size() == n && n > 0) begin
      for (int i = 0; i < n; i++)
        if ({obs_done[i], obs_par[i], obs_y[i]} !== {exp_done[i], exp_par[i], exp_y[i]}) begin
          bad = i;
          break;
        end
      idx = (bad < 0) ? n - 1 : bad;
      chk({tag, "_data"}, int'({obs_done[idx], obs_par[idx], obs_y[idx]}),
                          int'({exp_done[idx], exp_par[idx], exp_y[idx]}));
      if (synd) chk({tag, "_synd"}, synd_or(), 0);
    end
    clear_q();
  endtask

  // Offer msg[0..n-1]; while in_ready=0, enable follows 'hold' with junk data x=FF.
  task automatic send(input int kin, input int n, input bit gaps, input bit hold);
    int i, guard;
    i = 0;
    guard = 0;
    while (i < n && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (!in_ready) begin
        enable = hold;
        x = 8'hFF;
      end else if (gaps && $urandom_range(3) == 0) begin
        enable = 1'b0;
        x = 8'($urandom);
      end else begin
        enable = 1'b1;
        x = msg[i];
        k = (i == 0) ? kin[7:0] : 8'($urandom);
        i++;
      end
    end
    chk("send_bound", i, n);
  endtask

  task automatic drain();
    @(negedge clk);
    enable = 1'b0;
    repeat (18) @(negedge clk);
  endtask

  task automatic rand_msg(input int n);
    msg.delete();
    repeat (n) msg.push_back(8'($urandom));
  endtask

  initial begin
    int v, kk;
    v = 1;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = v[7:0];
      glog[v] = i;
      v = v << 1;
      if (v > 255) v = v ^ 'h11D;
    end
    gexp[255] = gexp[0];
    glog[0] = 0;
    for (int i = 0; i <= 16; i++) gpoly[i] = 8'h00;
    gpoly[0] = 8'h01;
    for (int i = 0; i < 16; i++) begin
      for (int j = 16; j > 0; j--) gpoly[j] = gpoly[j-1] ^ gf_mul(gpoly[j], gexp[i]);
      gpoly[0] = gf_mul(gpoly[0], gexp[i]);
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_y", int'(y), 0);
    chk("rst_y_valid", int'(y_valid), 0);
    chk("rst_y_par", int'(y_par), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    clrn = 1'b1;
    @(negedge clk);

    // 1: all-zero full-length block
    msg.delete();
    repeat (239) msg.push_back(8'h00);
    build_exp(239);
    send(239, 239, 1'b0, 1'b1);
    drain();
    check_block("t1_zero", 1'b1);

    // 2 + 5: k=1, x=01 gives g15..g0; junk offered during PAR must be dropped
    rdy_low = 0;
    msg.delete();
    msg.push_back(8'h01);
    exp_y.push_back(8'h01); exp_par.push_back(1'b0); exp_done.push_back(1'b0);
    for (int m = 15; m >= 0; m--) begin
      exp_y.push_back(gpoly[m]); exp_par.push_back(1'b1); exp_done.push_back(m == 0);
    end
    send(1, 1, 1'b0, 1'b1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!in_ready) begin
        enable = 1'b1;
        x = 8'hFF;
      end else begin
        enable = 1'b0;
        break;
      end
    end
    repeat (3) @(negedge clk);
    chk("t2_rdy_low", rdy_low, 16);
    chk("t2_hold_y", int'(y), int'(gpoly[0]));
    check_block("t2_gen", 1'b1);

    // 4: k=5 then k=239 back to back with enable held high
    rdy_low = 0;
    rand_msg(5);
    build_exp(5);
    send(5, 5, 1'b0, 1'b1);
    rand_msg(239);
    build_exp(239);
    send(239, 239, 1'b0, 1'b1);
    drain();
    chk("t4_rdy_low", rdy_low, 32);
    if (obs_cyc.size() > 0)
      chk("t4_contig", obs_cyc[obs_cyc.size()-1] - obs_cyc[0] + 1, 276);
    check_block("t4_b2b", 1'b0);

    // 5: out-of-range k clamps to 239
    rand_msg(239);
    build_exp(239);
    send(0, 239, 1'b0, 1'b0);
    drain();
    check_block("t5_k0", 1'b1);
    rand_msg(239);
    build_exp(239);
    send(250, 239, 1'b1, 1'b0);
    drain();
    check_block("t5_k250", 1'b1);

    // 3: random lengths and data, with and without input gaps
    for (int b = 0; b < 200; b++) begin
      kk = $urandom_range(239, 1);
      rand_msg(kk);
      build_exp(kk);
      send(kk, kk, b[0], (b % 3) == 0);
      drain();
      check_block("t3_rand", 1'b1);
    end

    // 6: reset asserted during the 100th message byte aborts the block
    rand_msg(239);
    send(239, 99, 1'b0, 1'b0);
    @(negedge clk);
    enable = 1'b1;
    x = msg[99];
    clrn = 1'b0;
    #1;
    chk("t6_async_y_valid", int'(y_valid), 0);
    @(negedge clk);
    chk("t6_rst_y", int'(y), 0);
    chk("t6_rst_y_valid", int'(y_valid), 0);
    chk("t6_rst_y_par", int'(y_par), 0);
    chk("t6_rst_done", int'(done), 0);
    chk("t6_rst_in_ready", int'(in_ready), 1);
    enable = 1'b0;
    clrn = 1'b1;
    clear_q();
    rand_msg(10);
    build_exp(10);
    send(10, 10, 1'b0, 1'b0);
    drain();
    check_block("t6_fresh", 1'b1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
